// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    STALL  = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && (count_q != '1)) count_d = count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_count = count_q;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencing: load-use stalls, taken-branch flushes and HALT drain,
// with saturating stall/flush event counters for the debug unit.
module hazard_flush_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH     = mips_pkg::REG_ADDR_WIDTH,
  parameter int unsigned LOAD_USE_STALLS    = 1,
  parameter int unsigned BRANCH_FLUSH_SLOTS = 1,
  parameter int unsigned DRAIN_CYCLES       = 4,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
  input  logic                      i_id_uses_rt,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rt,
  input  logic                      i_ex_memread,
  input  logic                      i_branch_taken,
  input  logic                      i_halt_id,
  input  logic                      i_resume,
  output logic                      o_pc_write,
  output logic                      o_ifid_write,
  output logic                      o_nop_select,
  output logic                      o_idex_bubble,
  output logic                      o_halted,
  output logic [CNT_WIDTH-1:0]      o_stall_count,
  output logic [CNT_WIDTH-1:0]      o_flush_count
);

  localparam int unsigned MAX_LF  = (LOAD_USE_STALLS > BRANCH_FLUSH_SLOTS) ?
                                    LOAD_USE_STALLS : BRANCH_FLUSH_SLOTS;
  localparam int unsigned SEQ_MAX = (MAX_LF > DRAIN_CYCLES) ? MAX_LF : DRAIN_CYCLES;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);

  localparam logic [SEQ_W-1:0] STALL_LOAD = SEQ_W'(LOAD_USE_STALLS - 1);
  localparam logic [SEQ_W-1:0] FLUSH_LOAD = SEQ_W'(BRANCH_FLUSH_SLOTS - 1);
  localparam logic [SEQ_W-1:0] DRAIN_LOAD = SEQ_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             lu_c;
  logic             stall_inc, flush_inc;

  assign lu_c = i_ex_memread && (i_ex_rt != '0) &&
                ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  // Next state and zero-latency pipeline controls.
  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_nop_select  = 1'b0;
    o_idex_bubble = 1'b0;
    o_halted      = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (state_q)
      RUN: begin
        if (lu_c) begin
          o_idex_bubble = 1'b1;
          stall_inc     = 1'b1;
          if (LOAD_USE_STALLS > 1) begin
            state_d = STALL;
            seq_d   = STALL_LOAD;
          end
        end else if (i_branch_taken) begin
          o_pc_write   = 1'b1;
          o_ifid_write = 1'b1;
          o_nop_select = 1'b1;
          flush_inc    = 1'b1;
          if (BRANCH_FLUSH_SLOTS > 1) begin
            state_d = FLUSH;
            seq_d   = FLUSH_LOAD;
          end
        end else if (i_halt_id) begin
          o_nop_select = 1'b1;
          state_d      = (DRAIN_CYCLES > 1) ? DRAIN : HALTED;
          seq_d        = DRAIN_LOAD;
        end else begin
          o_pc_write   = 1'b1;
          o_ifid_write = 1'b1;
        end
      end
      STALL: begin
        o_idex_bubble = 1'b1;
        stall_inc     = 1'b1;
        seq_d         = seq_q - SEQ_W'(1);
        if (seq_q <= SEQ_W'(1)) state_d = RUN;
      end
      FLUSH: begin
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_nop_select = 1'b1;
        flush_inc    = 1'b1;
        seq_d        = seq_q - SEQ_W'(1);
        if (seq_q <= SEQ_W'(1)) state_d = RUN;
      end
      DRAIN: begin
        o_nop_select  = 1'b1;
        o_idex_bubble = 1'b1;
        seq_d         = seq_q - SEQ_W'(1);
        if (seq_q <= SEQ_W'(1)) state_d = HALTED;
      end
      HALTED: begin
        o_halted      = 1'b1;
        o_nop_select  = 1'b1;
        o_idex_bubble = 1'b1;
        if (i_resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // Reset squashes everything in flight during the reset cycle itself.
    if (i_reset) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_nop_select  = 1'b1;
      o_idex_bubble = 1'b1;
      o_halted      = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      state_d       = RUN;
      seq_d         = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (stall_inc),
    .o_count (o_stall_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (flush_inc),
    .o_count (o_flush_count)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: two parameterisations driven in lockstep and
// compared every cycle against a pending-work reference model.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_uses_rt, ex_memread, br, halt, resume;
  logic [4:0] id_rs, id_rt, ex_rt;

  logic        a_pc, a_ifid, a_nop, a_bub, a_hlt;
  logic [1:0]  a_stall, a_flush;
  logic        b_pc, b_ifid, b_nop, b_bub, b_hlt;
  logic [15:0] b_stall, b_flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_USE_STALLS(1), .BRANCH_FLUSH_SLOTS(2),
                      .DRAIN_CYCLES(4), .CNT_WIDTH(2)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(id_uses_rt), .i_ex_rt(ex_rt), .i_ex_memread(ex_memread),
    .i_branch_taken(br), .i_halt_id(halt), .i_resume(resume),
    .o_pc_write(a_pc), .o_ifid_write(a_ifid), .o_nop_select(a_nop),
    .o_idex_bubble(a_bub), .o_halted(a_hlt),
    .o_stall_count(a_stall), .o_flush_count(a_flush)
  );

  hazard_flush_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_USE_STALLS(3), .BRANCH_FLUSH_SLOTS(1),
                      .DRAIN_CYCLES(2), .CNT_WIDTH(16)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(id_uses_rt), .i_ex_rt(ex_rt), .i_ex_memread(ex_memread),
    .i_branch_taken(br), .i_halt_id(halt), .i_resume(resume),
    .o_pc_write(b_pc), .o_ifid_write(b_ifid), .o_nop_select(b_nop),
    .o_idex_bubble(b_bub), .o_halted(b_hlt),
    .o_stall_count(b_stall), .o_flush_count(b_flush)
  );

  // Model: how many stall / flush / drain cycles are still owed, plus event totals.
  typedef struct {
    int stall_left;
    int flush_left;
    int drain_left;
    bit halted;
    int stalls;
    int flushes;
  } mdl_t;

  typedef struct {
    bit pc;
    bit ifid;
    bit nop;
    bit bub;
    bit hlt;
  } exp_t;

  mdl_t ma = '{0, 0, 0, 1'b0, 0, 0};
  mdl_t mb = '{0, 0, 0, 1'b0, 0, 0};

  function automatic int sat_inc(input int v, input int cmax);
    return (v < cmax) ? v + 1 : cmax;
  endfunction

  function automatic void model_step(input int lus, input int bfs, input int dc, input int cmax,
                                     input bit r, input bit lu, input bit b, input bit h,
                                     input bit res, input mdl_t mi,
                                     output mdl_t mo, output exp_t e);
    mo = mi;
    e  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    if (r) begin
      e  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      mo = '{0, 0, 0, 1'b0, 0, 0};
    end else if (mi.halted) begin
      e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      if (res) mo.halted = 1'b0;
    end else if (mi.drain_left > 0) begin
      e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      mo.drain_left = mi.drain_left - 1;
      if (mo.drain_left == 0) mo.halted = 1'b1;
    end else if (mi.stall_left > 0) begin
      e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      mo.stalls     = sat_inc(mi.stalls, cmax);
      mo.stall_left = mi.stall_left - 1;
    end else if (mi.flush_left > 0) begin
      e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      mo.flushes    = sat_inc(mi.flushes, cmax);
      mo.flush_left = mi.flush_left - 1;
    end else if (lu) begin
      e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      mo.stalls     = sat_inc(mi.stalls, cmax);
      mo.stall_left = lus - 1;
    end else if (b) begin
      e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      mo.flushes    = sat_inc(mi.flushes, cmax);
      mo.flush_left = bfs - 1;
    end else if (h) begin
      e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      mo.drain_left = dc - 1;
      if (dc == 1) mo.halted = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    tests++;
    assert (obs === 32'(expv)) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One cycle: drive, check combinational controls and current counters, advance model.
  task automatic cyc(input bit r, input bit mr, input logic [4:0] ert, input logic [4:0] rs_,
                     input logic [4:0] rt_, input bit ut, input bit b, input bit h,
                     input bit res);
    mdl_t na, nb;
    exp_t ea, eb;
    bit   lu;
    rst = r; ex_memread = mr; ex_rt = ert; id_rs = rs_; id_rt = rt_;
    id_uses_rt = ut; br = b; halt = h; resume = res;
    #1;
    lu = mr && (ert != 5'd0) && ((ert == rs_) || (ut && (ert == rt_)));
    model_step(1, 2, 4, 3,     r, lu, b, h, res, ma, na, ea);
    model_step(3, 1, 2, 65535, r, lu, b, h, res, mb, nb, eb);
    chk("a_pc_write",    32'(a_pc),   int'(ea.pc));
    chk("a_ifid_write",  32'(a_ifid), int'(ea.ifid));
    chk("a_nop_select",  32'(a_nop),  int'(ea.nop));
    chk("a_idex_bubble", 32'(a_bub),  int'(ea.bub));
    chk("a_halted",      32'(a_hlt),  int'(ea.hlt));
    chk("a_stall_count", 32'(a_stall), ma.stalls);
    chk("a_flush_count", 32'(a_flush), ma.flushes);
    chk("b_pc_write",    32'(b_pc),   int'(eb.pc));
    chk("b_ifid_write",  32'(b_ifid), int'(eb.ifid));
    chk("b_nop_select",  32'(b_nop),  int'(eb.nop));
    chk("b_idex_bubble", 32'(b_bub),  int'(eb.bub));
    chk("b_halted",      32'(b_hlt),  int'(eb.hlt));
    chk("b_stall_count", 32'(b_stall), mb.stalls);
    chk("b_flush_count", 32'(b_flush), mb.flushes);
    ma = na;
    mb = nb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ex_memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rt = 1'b0; br = 1'b0; halt = 1'b0; resume = 1'b0;
    @(negedge clk);

    // Reset state
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Load-use on rs, then the same with rt==0 (no hazard)
    cyc(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("a_stall_after_lu", 32'(a_stall), 1);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // rt-only hazard, without and with uses_rt
    cyc(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Taken branch: two squashed slots in dut_a
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("a_flush_after_br", 32'(a_flush), 2);

    // lu + branch together stalls only
    cyc(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Halt, resume ignored during drain, resume from halted
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("a_halted_cycle5", 32'(a_hlt), 1);
    idle(1);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Stall counter saturation in the 2-bit instance
    repeat (5) begin
      cyc(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
    end
    chk("a_stall_saturated", 32'(a_stall), 3);
    idle(2);

    // Reset during the second drain cycle
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_stall_after_rst", 32'(a_stall), 0);
    idle(2);

    // Randomized traffic with small register ranges to provoke hazards
    repeat (400) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
